// File: rtl/toy_mem_pkg.sv
// toy_mem_pkg: MMIO decode constants shared by the data responder (region match, register offsets, STATUS bit positions)
package toy_mem_pkg;
  localparam logic [25:0] MMIO_MATCH = 26'h3FF_FFFF;
  localparam logic [3:0] OFS_CYCLE = 4'h0;
  localparam logic [3:0] OFS_TXDATA = 4'h1;
  localparam logic [3:0] OFS_STATUS = 4'h2;
  localparam logic [3:0] OFS_SCRATCH = 4'h3;
  localparam logic [3:0] OFS_DROPS = 4'h4;
  localparam int ST_FULL = 0;
  localparam int ST_EMPTY = 1;
  localparam int ST_COUNT = 4;
endpackage

// File: rtl/toy_out_fifo.sv
// toy_out_fifo: sync FIFO, no fall-through; ports CLK/RST, i_push/i_data in, i_pop in, o_full/o_empty/o_count/o_head out (head reads 0 when empty)
module toy_out_fifo #(
  parameter int DEPTH = 4,
  parameter int W = 32
) (
  input  logic                       CLK,
  input  logic                       RST,
  input  logic                       i_push,
  input  logic [W-1:0]               i_data,
  input  logic                       i_pop,
  output logic                       o_full,
  output logic                       o_empty,
  output logic [$clog2(DEPTH):0]     o_count,
  output logic [W-1:0]               o_head
);
  localparam int PW = $clog2(DEPTH);
  logic [W-1:0] r_mem [DEPTH];
  logic [PW-1:0] r_wr, r_rd;
  logic [PW:0] r_count;
  logic w_push, w_pop;
  assign o_full = r_count == (PW+1)'(DEPTH);
  assign o_empty = r_count == '0;
  assign o_count = r_count;
  assign o_head = o_empty ? '0 : r_mem[r_rd];
  assign w_pop = i_pop & ~o_empty;
  assign w_push = i_push & (~o_full | w_pop);
  always_ff @(posedge CLK or posedge RST)
    if (RST) begin
      r_wr <= '0;
      r_rd <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_wr <= r_wr + 1'b1;
      if (w_pop) r_rd <= r_rd + 1'b1;
      r_count <= r_count + (PW+1)'(w_push) - (PW+1)'(w_pop);
    end
  always_ff @(posedge CLK)
    if (w_push) r_mem[r_wr] <= i_data;
endmodule

// File: rtl/toy_data_responder.sv
// toy_data_responder: data-port responder with word RAM + MMIO (CYCLE/TXDATA/STATUS/SCRATCH/DROPS); ports CLK/RST, DREQ/DRW/DADDR/DWDATA in, DRDATA out, OUT_VALID/OUT_DATA out with OUT_READY in
module toy_data_responder
  import toy_mem_pkg::*;
#(
  parameter int AW = 10,
  parameter int ENTRY = 1024,
  parameter int FIFO_DEPTH = 4
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        DREQ,
  input  logic        DRW,
  input  logic [29:0] DADDR,
  input  logic [31:0] DWDATA,
  output logic [31:0] DRDATA,
  output logic        OUT_VALID,
  output logic [31:0] OUT_DATA,
  input  logic        OUT_READY
);
  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  logic [31:0] r_mem [ENTRY];
  logic [31:0] r_cycle, r_scratch, r_rdata, w_status, w_mmio_rd, w_head;
  logic [15:0] r_drops;
  logic [3:0] w_ofs;
  logic [CW-1:0] w_count;
  logic w_mmio, w_wr, w_rd, w_tx, w_full, w_empty, w_pop;
  assign w_mmio = DADDR[29:4] == MMIO_MATCH;
  assign w_ofs = DADDR[3:0];
  assign w_wr = DREQ & DRW;
  assign w_rd = DREQ & ~DRW;
  assign w_tx = w_wr & w_mmio & (w_ofs == OFS_TXDATA);
  assign w_pop = OUT_READY & ~w_empty;
  toy_out_fifo #(.DEPTH(FIFO_DEPTH), .W(32)) u_fifo (
    .CLK(CLK), .RST(RST), .i_push(w_tx), .i_data(DWDATA), .i_pop(w_pop),
    .o_full(w_full), .o_empty(w_empty), .o_count(w_count), .o_head(w_head)
  );
  always_comb begin
    w_status = '0;
    w_status[ST_FULL] = w_full;
    w_status[ST_EMPTY] = w_empty;
    w_status[ST_COUNT +: 4] = 4'(w_count);
  end
  assign w_mmio_rd = w_ofs == OFS_CYCLE   ? r_cycle :
                     w_ofs == OFS_STATUS  ? w_status :
                     w_ofs == OFS_SCRATCH ? r_scratch :
                     w_ofs == OFS_DROPS   ? {16'd0, r_drops} : '0;
  always_ff @(posedge CLK)
    if (w_wr & ~w_mmio) r_mem[DADDR[AW-1:0]] <= DWDATA;
  always_ff @(posedge CLK or posedge RST)
    if (RST) begin
      r_cycle <= '0;
      r_scratch <= '0;
      r_drops <= '0;
      r_rdata <= '0;
    end else begin
      r_cycle <= r_cycle + 32'd1;
      if (w_wr & w_mmio & (w_ofs == OFS_SCRATCH)) r_scratch <= DWDATA;
      // a simultaneous pop frees the slot, so only a push that still finds the FIFO full is a drop
      if (w_tx & w_full & ~w_pop & ~&r_drops) r_drops <= r_drops + 16'd1;
      if (w_rd) r_rdata <= w_mmio ? w_mmio_rd : r_mem[DADDR[AW-1:0]];
    end
  assign DRDATA = r_rdata;
  assign OUT_VALID = ~w_empty;
  assign OUT_DATA = w_head;
endmodule

// File: tb/tb_toy_data_responder.sv
// tb_toy_data_responder: scoreboard bench for toy_data_responder (RAM, alias, CYCLE, FIFO/DROPS, same-cycle push/pop, mid-run reset)
module tb_toy_data_responder;
  logic CLK, RST, DREQ, DRW, OUT_VALID, OUT_READY;
  logic [29:0] DADDR;
  logic [31:0] DWDATA, DRDATA, OUT_DATA;
  int n_chk = 0;
  int n_pass = 0;
  logic [31:0] exp_q[$];
  string tag_q[$];
  logic [31:0] out_q[$];
  localparam logic [29:0] A_CYC = 30'h3FFF_FFF0;
  localparam logic [29:0] A_TX = 30'h3FFF_FFF1;
  localparam logic [29:0] A_ST = 30'h3FFF_FFF2;
  localparam logic [29:0] A_SCR = 30'h3FFF_FFF3;
  localparam logic [29:0] A_DRP = 30'h3FFF_FFF4;
  toy_data_responder #(.AW(10), .ENTRY(1024), .FIFO_DEPTH(4)) dut (
    .CLK(CLK), .RST(RST), .DREQ(DREQ), .DRW(DRW), .DADDR(DADDR), .DWDATA(DWDATA),
    .DRDATA(DRDATA), .OUT_VALID(OUT_VALID), .OUT_DATA(OUT_DATA), .OUT_READY(OUT_READY)
  );
  initial CLK = 0;
  always #5 CLK = ~CLK;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask
  task automatic model_edge(input logic push, input logic [31:0] d);
    if (OUT_READY && out_q.size() > 0) begin
      check("out_valid", {31'd0, OUT_VALID}, 32'd1);
      check("out_data", OUT_DATA, out_q.pop_front());
    end
    if (push && out_q.size() < 4) out_q.push_back(d);
  endtask
  task automatic op(input logic w, input logic [29:0] a, input logic [31:0] d, input string tag);
    @(negedge CLK);
    DREQ = 1;
    DRW = w;
    DADDR = a;
    DWDATA = d;
    model_edge(w && a == A_TX, d);
    if (!w) begin
      exp_q.push_back(d);
      tag_q.push_back(tag);
    end
    @(posedge CLK);
    #1;
    DREQ = 0;
    DRW = 0;
    if (!w) check(tag_q.pop_front(), DRDATA, exp_q.pop_front());
  endtask
  task automatic idle();
    @(negedge CLK);
    model_edge(1'b0, 32'd0);
    @(posedge CLK);
    #1;
  endtask
  task automatic drain();
    OUT_READY = 1;
    repeat (6) idle();
    check("drained_valid", {31'd0, OUT_VALID}, 32'd0);
    OUT_READY = 0;
  endtask
  initial begin
    #200000;
    $display("FAIL timeout");
    $fatal(1, "timeout");
  end
  initial begin
    RST = 1;
    DREQ = 0;
    DRW = 0;
    DADDR = '0;
    DWDATA = '0;
    OUT_READY = 0;
    repeat (2) @(posedge CLK);
    #1;
    check("rst_drdata", DRDATA, 32'd0);
    check("rst_out_valid", {31'd0, OUT_VALID}, 32'd0);
    check("rst_out_data", OUT_DATA, 32'd0);
    RST = 0;
    repeat (10) @(posedge CLK);
    op(0, A_CYC, 32'd10, "cycle_10");
    op(1, 30'd5, 32'hDEADBEEF, "");
    op(0, 30'd5, 32'hDEADBEEF, "ram_rd");
    op(0, 30'd1029, 32'hDEADBEEF, "ram_alias");
    op(0, A_SCR, 32'd0, "scratch_rst");
    force dut.r_cycle = 32'hFFFF_FFFF;
    #1;
    release dut.r_cycle;
    op(0, A_CYC, 32'hFFFF_FFFF, "cycle_max");
    op(0, A_CYC, 32'd0, "cycle_wrap");
    op(1, A_CYC, 32'h5555_5555, "");
    op(0, A_ST, 32'h0000_0002, "status_empty");
    for (int i = 1; i <= 6; i++) op(1, A_TX, 32'(i), "");
    op(0, A_ST, 32'h0000_0041, "status_full");
    op(0, A_DRP, 32'd2, "drops_2");
    drain();
    op(0, A_ST, 32'h0000_0002, "status_drained");
    for (int i = 0; i < 4; i++) op(1, A_TX, 32'h10 + 32'(i), "");
    OUT_READY = 1;
    op(1, A_TX, 32'hAA, "");
    OUT_READY = 0;
    op(0, A_ST, 32'h0000_0041, "status_pushpop");
    op(0, A_DRP, 32'd2, "drops_pushpop");
    drain();
    op(1, A_SCR, 32'h1234_5678, "");
    op(0, A_SCR, 32'h1234_5678, "scratch_rd");
    for (int i = 0; i < 4; i++) op(1, A_TX, 32'h20 + 32'(i), "");
    OUT_READY = 1;
    idle();
    @(negedge CLK);
    RST = 1;
    #1;
    check("midrst_valid", {31'd0, OUT_VALID}, 32'd0);
    check("midrst_drdata", DRDATA, 32'd0);
    @(posedge CLK);
    #1;
    RST = 0;
    OUT_READY = 0;
    out_q.delete();
    op(0, A_CYC, 32'd0, "midrst_cycle");
    op(0, A_SCR, 32'd0, "midrst_scratch");
    op(0, A_DRP, 32'd0, "midrst_drops");
    op(0, A_ST, 32'h0000_0002, "midrst_status");
    op(0, 30'd5, 32'hDEADBEEF, "midrst_ram");
    check("midrst_valid_after", {31'd0, OUT_VALID}, 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
